// File: rtl/ldst_mem_responder_if.sv
// Load/store port between the core and the data-memory responder.
// The core drives the request fields and the responder drives stall and response.
interface ldst_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              stall_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output req_i, write_i, addr_i, wdata_i,
    input  rdata_o, stall_o, ack_o, err_o
  );

  modport slave (
    input  req_i, write_i, addr_i, wdata_i,
    output rdata_o, stall_o, ack_o, err_o
  );
endinterface

// File: rtl/ldst_mem_responder.sv
// Data-memory responder: word RAM behind a fixed wait-state handshake,
// with saturating load/store access counters.
module ldst_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  ldst_mem_if.slave   bus,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int         CNT_INIT_I = (LATENCY > 0) ? (LATENCY - 1) : 0;
  localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];
  localparam bit         ZERO_LAT   = (LATENCY == 0);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [31:0]       r_rd_cnt;
  logic [31:0]       r_wr_cnt;
  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_idle_req;
  logic                  w_do_access;
  logic                  w_acc_write;
  logic [ADDR_W-1:0]     w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_in_range;
  logic [DATA_W-1:0]     w_resp;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_idle_req  = (r_state == S_IDLE) && bus.req_i;
  assign w_do_access = (w_idle_req && ZERO_LAT) ||
                       ((r_state == S_BUSY) && (r_cnt == 4'd0));

  // With zero latency the access happens in the accepting cycle, before the latch.
  assign w_acc_write = (r_state == S_IDLE) ? bus.write_i : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr_i  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.wdata_i : r_wdata;

  assign w_index    = w_acc_addr[DEPTH_LOG2-1:0];
  assign w_in_range = (w_acc_addr[ADDR_W-1:DEPTH_LOG2] == '0);
  assign w_resp     = !w_in_range ? '0 :
                      (w_acc_write ? w_acc_wdata : r_mem[w_index]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_rd_cnt <= 32'd0;
      r_wr_cnt <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_i) begin
            if (ZERO_LAT) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else               r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_do_access) begin
        r_rdata <= w_resp;
        r_err   <= !w_in_range;
        if (w_acc_write) r_wr_cnt <= sat_inc(r_wr_cnt);
        else             r_rd_cnt <= sat_inc(r_rd_cnt);
      end
    end
  end

  // Request fields are only captured on acceptance; BUSY-cycle input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_idle_req) begin
      r_write <= bus.write_i;
      r_addr  <= bus.addr_i;
      r_wdata <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_do_access && w_acc_write && w_in_range)
      r_mem[w_index] <= w_acc_wdata;
  end

  // Stall drops as soon as reset asserts, abandoning any transaction in flight.
  assign bus.stall_o = reset && (w_idle_req || (r_state == S_BUSY));
  assign bus.ack_o   = (r_state == S_DONE);
  assign bus.err_o   = (r_state == S_DONE) && r_err;
  assign bus.rdata_o = r_rdata;

  assign rd_count_o = r_rd_cnt;
  assign wr_count_o = r_wr_cnt;

endmodule

// File: doc/ldst_mem_responder.md
Name: ldst_mem_responder

Overview:
- Data-memory responder at the far end of the core's load/store port: accepts the address, write flag and store data, and returns load data.
- Inserts a configurable number of wait states and drives the stall back to the core while a transaction is in flight.
- Backed by an internal word-addressed RAM.
- Also keeps saturating read/write access counters for performance bring-up.

Parameters:
- ADDR_W, 32, width of the load/store address bus.
- DATA_W, 32, data word width; matches the core operand width.
- DEPTH_LOG2, 10, log2 of the RAM depth in words.
- LATENCY, 2, wait states added before the access completes; legal range 0..15.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  1  access request; the core holds it and all request fields stable while stall_o=1.
- write_i  input  1  1 = store, 0 = load.
- addr_i  input  ADDR_W  word address.
- wdata_i  input  DATA_W  store data.
- rdata_o  output  DATA_W  load data; valid while ack_o=1.
- stall_o  output  1  core must hold the request and freeze the pipeline.
- ack_o  output  1  single-cycle completion strobe.
- err_o  output  1  out-of-range access; valid with ack_o.
- rd_count_o  output  32  completed loads, saturating.
- wr_count_o  output  32  completed stores, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, rdata_o=0, ack_o=0, err_o=0, both counters=0. RAM contents are not cleared.
- Reset mid-transaction: the transaction is abandoned. A pending store is not written and stall_o drops immediately.
- States: IDLE, BUSY, DONE.
- IDLE, req_i=1:
  - stall_o=1 combinationally in this cycle.
  - Latch write_i, addr_i and wdata_i.
  - If LATENCY=0, perform the access at this edge and go to DONE.
  - Otherwise set cnt=LATENCY-1 and go to BUSY.
- IDLE, req_i=0: stall_o=0; stay in IDLE.
- BUSY:
  - stall_o=1.
  - If cnt!=0, decrement cnt.
  - If cnt=0, perform the access at this edge and go to DONE.
- DONE:
  - stall_o=0 and ack_o=1 for exactly one cycle.
  - rdata_o holds the response.
  - Always return to IDLE; req_i in this cycle is the acknowledged request and is ignored.
- Total stall cycles per access = LATENCY+1. Access period = LATENCY+2 cycles. The next request is accepted no earlier than the IDLE cycle after DONE.
- Access rules:
  - Index = latched addr[DEPTH_LOG2-1:0]. In range iff addr[ADDR_W-1:DEPTH_LOG2]=0.
  - Load: rdata_o=RAM[index]; rd_count_o increments.
  - Store: RAM[index]=wdata; rdata_o=wdata (echo); wr_count_o increments.
  - Out of range: no RAM write, rdata_o=0, err_o=1 in DONE; the relevant counter still increments.
- Latched fields are used; changes to request inputs during BUSY are ignored.
- Counters saturate at 32'hFFFFFFFF and do not wrap.
- ack_o and err_o are 0 outside DONE. rdata_o holds its last value outside DONE.
- Simultaneous deassertion of req_i during BUSY is a protocol violation; the access still completes.

Test Plan:
- LATENCY=2: store addr=5, data=32'hDEADBEEF; then load addr=5 -> stall_o high 3 cycles each; ack_o pulses once each; load returns 32'hDEADBEEF; wr_count_o=1, rd_count_o=1.
- LATENCY=0: back-to-back loads to addr 0 and 1 preloaded with 11 and 22 -> 1 stall cycle each; ack_o every 2nd cycle; data 11 then 22.
- Out of range, DEPTH_LOG2=10: store to addr=32'h400 then load addr=32'h000 -> err_o=1 on the store ack; RAM[0] unchanged; load of 32'h400 gives rdata 0 with err_o=1.
- Reset mid-op: assert reset during BUSY of a store to addr 3 -> stall_o=0 and ack_o=0 immediately; a later load of addr 3 returns its old value; counters=0.
- Input change during BUSY: change addr_i from 7 to 8 mid-BUSY -> the response reflects addr 7.
- Saturation: force wr_count_o to 32'hFFFFFFFE, perform 3 stores -> reads 32'hFFFFFFFF and holds.
